// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB and decodes datapath strobes
// from the current state and the IR opcode.
module multicycle_ctrl #(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 3
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    output logic               PCWre,
    output logic               IRWre,
    output logic               InsMemRW,
    output logic               RegWre,
    output logic               RegOut,
    output logic               ALUSrcB,
    output logic               ALUM2Reg,
    output logic               DataMemRW,
    output logic               ExtSel,
    output logic [1:0]         PCSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         state
);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b010000);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b010001);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'b010010);
    localparam logic [OP_W-1:0] OP_MOVE = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b100110);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100111);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b110000);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(6'b111111);

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b100);

    typedef enum logic [2:0] {
        S_IF    = 3'b000,
        S_ID    = 3'b001,
        S_EXE_R = 3'b010,
        S_EXE_B = 3'b011,
        S_EXE_M = 3'b100,
        S_MEM   = 3'b101,
        S_WB    = 3'b110,
        S_HALT  = 3'b111
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_run;
    logic   w_en;
    logic   w_in_exec;
    logic   w_is_alu;
    logic   w_is_lw;
    logic   w_is_sw;
    logic   w_is_beq;
    logic   w_is_halt;
    logic   w_is_nop;

    assign w_is_alu  = (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB) || (op == OP_ORI) ||
                       (op == OP_AND) || (op == OP_OR)   || (op == OP_MOVE);
    assign w_is_lw   = (op == OP_LW);
    assign w_is_sw   = (op == OP_SW);
    assign w_is_beq  = (op == OP_BEQ);
    assign w_is_halt = (op == OP_HALT);
    assign w_is_nop  = !(w_is_alu || w_is_lw || w_is_sw || w_is_beq || w_is_halt);

    // r_run holds the FSM idle in IF until the first rising edge after reset release,
    // so the first real fetch cycle is a full clock period.
    assign w_en      = Reset && r_run;
    assign w_in_exec = (r_state != S_IF) && (r_state != S_HALT);
    assign state     = r_state;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IF:    w_next_state = S_ID;
            S_ID: begin
                if (w_is_halt)               w_next_state = S_HALT;
                else if (w_is_beq)           w_next_state = S_EXE_B;
                else if (w_is_lw || w_is_sw) w_next_state = S_EXE_M;
                else if (w_is_alu)           w_next_state = S_EXE_R;
                else                         w_next_state = S_IF;
            end
            S_EXE_R: w_next_state = S_WB;
            S_EXE_B: w_next_state = S_IF;
            S_EXE_M: w_next_state = S_MEM;
            S_MEM:   w_next_state = w_is_lw ? S_WB : S_IF;
            S_WB:    w_next_state = S_IF;
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_IF;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IF;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_run) r_state <= w_next_state;
        end
    end

    // Strobes depend on zero and op in the same cycle, so they decode combinationally.
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        DataMemRW = 1'b0;
        ALUM2Reg  = 1'b0;
        PCSrc     = 2'b00;
        case (r_state)
            S_IF: begin
                InsMemRW = 1'b1;
                IRWre    = w_en;
            end
            S_ID:    PCWre = w_en && w_is_nop;
            S_EXE_B: begin
                PCWre = w_en;
                PCSrc = zero ? 2'b01 : 2'b00;
            end
            S_MEM: begin
                DataMemRW = w_en && w_is_sw;
                PCWre     = w_en && w_is_sw;
            end
            S_WB: begin
                RegWre   = w_en;
                PCWre    = w_en;
                ALUM2Reg = w_is_lw;
            end
            default: ;
        endcase
    end

    // Opcode-static controls, held for the whole ID..WB span.
    always_comb begin
        ALUOp   = ALU_ADD;
        ALUSrcB = 1'b0;
        ExtSel  = 1'b0;
        RegOut  = 1'b0;
        if (w_in_exec) begin
            case (op)
                OP_SUB, OP_BEQ: ALUOp = ALU_SUB;
                OP_OR, OP_ORI:  ALUOp = ALU_OR;
                OP_AND:         ALUOp = ALU_AND;
                default:        ALUOp = ALU_ADD;
            endcase
            ALUSrcB = (op == OP_ADDI) || (op == OP_ORI) || w_is_lw || w_is_sw;
            ExtSel  = (op != OP_ORI);
            RegOut  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                      (op == OP_OR)  || (op == OP_MOVE);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: per-cycle state/strobe vectors and
// opcode decode checked against hand-computed tables, sampled mid-cycle.
module tb_multicycle_ctrl;

    logic       CLK;
    logic       Reset;
    logic [5:0] op;
    logic       zero;
    logic       PCWre, IRWre, InsMemRW, RegWre, RegOut, ALUSrcB, ALUM2Reg, DataMemRW, ExtSel;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl #(.OP_W(6), .ALUOP_W(3)) dut (
        .CLK(CLK), .Reset(Reset), .op(op), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
        .RegOut(RegOut), .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg), .DataMemRW(DataMemRW),
        .ExtSel(ExtSel), .PCSrc(PCSrc), .ALUOp(ALUOp), .state(state)
    );

    // {state, PCWre, IRWre, InsMemRW, RegWre, DataMemRW, PCSrc}
    wire [9:0] w_obs = {state, PCWre, IRWre, InsMemRW, RegWre, DataMemRW, PCSrc};
    // {RegOut, ALUSrcB, ALUM2Reg, ExtSel, ALUOp}
    wire [6:0] w_dec = {RegOut, ALUSrcB, ALUM2Reg, ExtSel, ALUOp};

    localparam logic [9:0] E_RST  = 10'b000_0_0_1_0_0_00;
    localparam logic [9:0] E_IF   = 10'b000_0_1_1_0_0_00;
    localparam logic [9:0] E_ID   = 10'b001_0_0_0_0_0_00;
    localparam logic [9:0] E_IDN  = 10'b001_1_0_0_0_0_00;
    localparam logic [9:0] E_EXR  = 10'b010_0_0_0_0_0_00;
    localparam logic [9:0] E_EXB1 = 10'b011_1_0_0_0_0_01;
    localparam logic [9:0] E_EXB0 = 10'b011_1_0_0_0_0_00;
    localparam logic [9:0] E_EXM  = 10'b100_0_0_0_0_0_00;
    localparam logic [9:0] E_MEML = 10'b101_0_0_0_0_0_00;
    localparam logic [9:0] E_MEMS = 10'b101_1_0_0_0_1_00;
    localparam logic [9:0] E_WB   = 10'b110_1_0_0_1_0_00;
    localparam logic [9:0] E_HALT = 10'b111_0_0_0_0_0_00;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b010000;
    localparam logic [5:0] OP_AND = 6'b010001;
    localparam logic [5:0] OP_SW  = 6'b100110;
    localparam logic [5:0] OP_LW  = 6'b100111;
    localparam logic [5:0] OP_BEQ = 6'b110000;
    localparam logic [5:0] OP_HLT = 6'b111111;
    localparam logic [5:0] OP_NOP = 6'b000011;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); #1;
            checks++;
            if (w_obs !== E_RST) begin
                errors++; $display("FAIL reset cyc%0d: got %b expected %b", i, w_obs, E_RST);
            end
        end
        Reset = 1'b1;
        @(negedge CLK); op = OP_NOP; #1;
        checks++;
        if (w_obs !== E_IF) begin
            errors++; $display("FAIL first_if: got %b expected %b", w_obs, E_IF);
        end
        @(negedge CLK); #1;
        checks++;
        if (w_obs !== E_IDN) begin
            errors++; $display("FAIL nop_id: got %b expected %b", w_obs, E_IDN);
        end
    endtask

    task automatic test_add();
        logic [9:0] exp [4] = '{E_IF, E_ID, E_EXR, E_WB};
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); if (i == 0) op = OP_ADD; #1;
            checks++;
            if (w_obs !== exp[i]) begin
                errors++; $display("FAIL add cyc%0d: got %b expected %b", i, w_obs, exp[i]);
            end
            checks++;
            if (w_dec !== ((i == 0) ? 7'b0000000 : 7'b1001000)) begin
                errors++; $display("FAIL add_dec cyc%0d: got %b", i, w_dec);
            end
        end
    endtask

    task automatic test_alu_decode();
        logic [5:0] ops  [2] = '{OP_ORI, OP_AND};
        logic [6:0] decs [2] = '{7'b0100011, 7'b1001100};
        logic [9:0] exp  [4] = '{E_IF, E_ID, E_EXR, E_WB};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge CLK); if (i == 0) op = ops[k]; #1;
                checks++;
                if (w_obs !== exp[i]) begin
                    errors++; $display("FAIL alu%0d cyc%0d: got %b expected %b", k, i, w_obs, exp[i]);
                end
                if (i == 1) begin
                    checks++;
                    if (w_dec !== decs[k]) begin
                        errors++; $display("FAIL alu%0d_dec: got %b expected %b", k, w_dec, decs[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_beq();
        logic [9:0] exp1 [3] = '{E_IF, E_ID, E_EXB1};
        logic [9:0] exp0 [3] = '{E_IF, E_ID, E_EXB0};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge CLK);
                if (i == 0) begin op = OP_BEQ; zero = (k == 0); end
                #1;
                checks++;
                if (w_obs !== ((k == 0) ? exp1[i] : exp0[i])) begin
                    errors++; $display("FAIL beq_z%0d cyc%0d: got %b", 1 - k, i, w_obs);
                end
                if (i == 2) begin
                    checks++;
                    if (w_dec !== 7'b0001001) begin
                        errors++; $display("FAIL beq_dec: got %b expected %b", w_dec, 7'b0001001);
                    end
                end
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_lw_sw();
        logic [9:0] expl [5] = '{E_IF, E_ID, E_EXM, E_MEML, E_WB};
        logic [9:0] exps [4] = '{E_IF, E_ID, E_EXM, E_MEMS};
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK); if (i == 0) op = OP_LW; #1;
            checks++;
            if (w_obs !== expl[i]) begin
                errors++; $display("FAIL lw cyc%0d: got %b expected %b", i, w_obs, expl[i]);
            end
        end
        checks++;
        if (w_dec !== 7'b0111000) begin
            errors++; $display("FAIL lw_wb_dec: got %b expected %b", w_dec, 7'b0111000);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); if (i == 0) op = OP_SW; #1;
            checks++;
            if (w_obs !== exps[i]) begin
                errors++; $display("FAIL sw cyc%0d: got %b expected %b", i, w_obs, exps[i]);
            end
        end
        checks++;
        if (w_dec !== 7'b0101000) begin
            errors++; $display("FAIL sw_mem_dec: got %b expected %b", w_dec, 7'b0101000);
        end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 22; i++) begin
            @(negedge CLK); if (i == 0) op = OP_HLT; #1;
            checks++;
            if (w_obs !== ((i == 0) ? E_IF : (i == 1) ? E_ID : E_HALT)) begin
                errors++; $display("FAIL halt cyc%0d: got %b", i, w_obs);
            end
        end
        checks++;
        if (w_dec !== 7'b0000000) begin
            errors++; $display("FAIL halt_dec: got %b expected %b", w_dec, 7'b0000000);
        end
        @(negedge CLK); Reset = 1'b0; #1;
        checks++;
        if (w_obs !== E_RST) begin
            errors++; $display("FAIL halt_reset: got %b expected %b", w_obs, E_RST);
        end
        @(negedge CLK); Reset = 1'b1; #1;
        checks++;
        if (w_obs !== E_RST) begin
            errors++; $display("FAIL halt_release: got %b expected %b", w_obs, E_RST);
        end
    endtask

    task automatic test_reset_mid_sw();
        logic [9:0] exp [3] = '{E_IF, E_ID, E_EXM};
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); if (i == 0) op = OP_SW; #1;
            checks++;
            if (w_obs !== exp[i]) begin
                errors++; $display("FAIL sw_abort cyc%0d: got %b expected %b", i, w_obs, exp[i]);
            end
        end
        Reset = 1'b0; #1;
        checks++;
        if (w_obs !== E_RST) begin
            errors++; $display("FAIL sw_abort_async: got %b expected %b", w_obs, E_RST);
        end
        @(negedge CLK); #1;
        checks++;
        if (w_obs !== E_RST) begin
            errors++; $display("FAIL sw_abort_hold: got %b expected %b", w_obs, E_RST);
        end
        Reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp [13] = '{E_IF, E_ID, E_EXM, E_MEMS,
                                 E_IF, E_ID, E_EXM, E_MEML, E_WB,
                                 E_IF, E_ID, E_EXB0, E_IF};
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            if (i == 0) op = OP_SW;
            if (i == 4) op = OP_LW;
            if (i == 9) op = OP_BEQ;
            if (i == 12) op = OP_NOP;
            #1;
            checks++;
            if (w_obs !== exp[i]) begin
                errors++; $display("FAIL b2b cyc%0d: got %b expected %b", i, w_obs, exp[i]);
            end
            checks++;
            if ((PCWre && IRWre) || (RegWre && DataMemRW)) begin
                errors++; $display("FAIL b2b_excl cyc%0d: got %b expected no overlap", i, w_obs);
            end
        end
    endtask

    initial begin
        Reset = 1'b0;
        op    = OP_ADD;
        zero  = 1'b0;
        test_reset();
        test_add();
        test_alu_decode();
        test_beq();
        test_lw_sw();
        test_halt();
        test_reset_mid_sw();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
